// File: rtl/prog_readback_pkg.sv
// Shared types and constants for the instruction-memory readback UART dumper.
package prog_readback_pkg;

    localparam int BYTES_PER_WORD = 4;
    localparam int DATA_BITS      = 8;
    localparam int CPB_WIDTH      = 16;

    // Readback sequencer states.
    typedef enum logic [2:0] {
        IDLE,
        RD_REQ,
        RD_WAIT,
        SEND,
        DONE
    } state_e;

    // A bit period of zero cycles is meaningless; treat it as one cycle.
    function automatic logic [CPB_WIDTH-1:0] cpb_eff(input logic [CPB_WIDTH-1:0] cpb);
        return (cpb == '0) ? CPB_WIDTH'(1) : cpb;
    endfunction

endpackage

// File: rtl/prog_readback_tx_uart_tx_byte.sv
// 8N1 byte serializer with valid/ready handshake and a runtime bit period.
// Ready is offered while idle and in the last cycle of a stop bit, so a new
// byte accepted then starts its start bit with no idle gap.
module uart_tx_byte
    import prog_readback_pkg::*;
(
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic [CPB_WIDTH-1:0] i_cpb,
    input  logic                 i_valid,
    input  logic [DATA_BITS-1:0] i_data,
    output logic                 o_ready,
    output logic                 o_tx
);

    logic                 r_active;
    logic [DATA_BITS:0]   r_frame;   // remaining data bits plus stop bit, LSB next
    logic [3:0]           r_bit;     // 0 = start, 1..8 = data, 9 = stop
    logic [CPB_WIDTH-1:0] r_cnt;
    logic                 r_tx;

    logic [CPB_WIDTH-1:0] w_cpb;
    logic                 w_bit_end;
    logic                 w_stop_end;
    logic                 w_load;

    assign w_cpb      = cpb_eff(i_cpb);
    assign w_bit_end  = (r_cnt == (w_cpb - CPB_WIDTH'(1)));
    assign w_stop_end = r_active && (r_bit == 4'(DATA_BITS + 1)) && w_bit_end;
    assign o_ready    = !r_active || w_stop_end;
    assign w_load     = i_valid && o_ready;
    assign o_tx       = r_tx;

    // Bit-period counter and shift register; the line is a registered output.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_active <= 1'b0;
            r_frame  <= '0;
            r_bit    <= '0;
            r_cnt    <= '0;
            r_tx     <= 1'b1;
        end else if (w_load) begin
            r_active <= 1'b1;
            r_frame  <= {1'b1, i_data};
            r_bit    <= '0;
            r_cnt    <= '0;
            r_tx     <= 1'b0;
        end else if (r_active) begin
            if (w_bit_end) begin
                r_cnt <= '0;
                if (r_bit == 4'(DATA_BITS + 1)) begin
                    r_active <= 1'b0;
                    r_tx     <= 1'b1;
                end else begin
                    r_tx    <= r_frame[0];
                    r_frame <= {1'b0, r_frame[DATA_BITS:1]};
                    r_bit   <= r_bit + 4'd1;
                end
            end else begin
                r_cnt <= r_cnt + CPB_WIDTH'(1);
            end
        end
    end

endmodule

// File: rtl/prog_readback_tx.sv
// Dumps the first word_count words of the instruction SRAM over a UART,
// little-endian byte order, with a two-cycle idle gap between words.
module prog_readback_tx
    import prog_readback_pkg::*;
#(
    parameter int AddrWidth = 8
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 start_i,
    input  logic [AddrWidth:0]   word_count_i,
    input  logic [15:0]          clks_per_bit_i,
    output logic                 mem_csb_o,
    output logic [AddrWidth-1:0] mem_addr_o,
    input  logic [31:0]          mem_rdata_i,
    output logic                 tx_o,
    output logic                 busy_o,
    output logic                 done_o
);

    state_e                 r_state;
    logic [AddrWidth:0]     r_word_count;
    logic [AddrWidth:0]     r_addr;      // one extra bit so 256 words never wraps
    logic [CPB_WIDTH-1:0]   r_cpb;
    logic [31:0]            r_buf;
    logic [2:0]             r_byte_idx;  // bytes handed to the serializer so far
    logic                   r_mem_csb;
    logic [AddrWidth-1:0]   r_mem_addr;
    logic                   r_busy;
    logic                   r_done;

    logic [AddrWidth:0]     w_addr_inc;
    logic                   w_all_sent;
    logic                   w_tx_valid;
    logic                   w_tx_ready;
    logic [DATA_BITS-1:0]   w_tx_data;
    logic                   w_tx;
    logic [DATA_BITS-1:0]   w_buf_byte [BYTES_PER_WORD];

    for (genvar gi = 0; gi < BYTES_PER_WORD; gi++) begin : g_lane
        assign w_buf_byte[gi] = r_buf[gi*DATA_BITS +: DATA_BITS];
    end

    assign w_addr_inc = r_addr + (AddrWidth+1)'(1);
    assign w_all_sent = (r_byte_idx == 3'(BYTES_PER_WORD));
    // Byte 0 comes straight from the SRAM output so its start bit begins on
    // the same edge the word is captured.
    assign w_tx_valid = (r_state == RD_WAIT) || ((r_state == SEND) && !w_all_sent);
    assign w_tx_data  = (r_state == RD_WAIT) ? mem_rdata_i[DATA_BITS-1:0]
                                             : w_buf_byte[r_byte_idx[1:0]];

    uart_tx_byte u_uart (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .i_cpb   (r_cpb),
        .i_valid (w_tx_valid),
        .i_data  (w_tx_data),
        .o_ready (w_tx_ready),
        .o_tx    (w_tx)
    );

    assign mem_csb_o  = r_mem_csb;
    assign mem_addr_o = r_mem_addr;
    assign tx_o       = w_tx;
    assign busy_o     = r_busy;
    assign done_o     = r_done;

    // Readback sequencer with registered SRAM strobe, busy and done.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state      <= IDLE;
            r_word_count <= '0;
            r_addr       <= '0;
            r_cpb        <= CPB_WIDTH'(1);
            r_buf        <= '0;
            r_byte_idx   <= '0;
            r_mem_csb    <= 1'b1;
            r_mem_addr   <= '0;
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (start_i) begin
                        r_word_count <= word_count_i;
                        r_cpb        <= cpb_eff(clks_per_bit_i);
                        r_addr       <= '0;
                        r_mem_addr   <= '0;
                        if (word_count_i == '0) begin
                            r_state <= DONE;
                            r_done  <= 1'b1;
                            r_busy  <= 1'b0;
                        end else begin
                            r_state   <= RD_REQ;
                            r_mem_csb <= 1'b0;
                            r_busy    <= 1'b1;
                        end
                    end
                end
                RD_REQ: begin
                    r_mem_csb <= 1'b1;
                    r_state   <= RD_WAIT;
                end
                RD_WAIT: begin
                    r_buf      <= mem_rdata_i;
                    r_byte_idx <= 3'd1;
                    r_state    <= SEND;
                end
                SEND: begin
                    if (w_tx_ready) begin
                        if (w_all_sent) begin
                            r_addr <= w_addr_inc;
                            if (w_addr_inc < r_word_count) begin
                                r_mem_addr <= w_addr_inc[AddrWidth-1:0];
                                r_mem_csb  <= 1'b0;
                                r_state    <= RD_REQ;
                            end else begin
                                r_state <= DONE;
                                r_done  <= 1'b1;
                                r_busy  <= 1'b0;
                            end
                        end else begin
                            r_byte_idx <= r_byte_idx + 3'd1;
                        end
                    end
                end
                DONE: begin
                    r_state <= IDLE;
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_prog_readback_tx.sv
// Directed bench for prog_readback_tx: SRAM model, cycle-accurate line capture
// and comparison against an ideal 8N1 waveform built from the memory image.
module tb_prog_readback_tx;

    localparam int AW = 8;

    logic          clk = 1'b0;
    logic          rst_i;
    logic          start_i;
    logic [AW:0]   word_count_i;
    logic [15:0]   clks_per_bit_i;
    logic          mem_csb_o;
    logic [AW-1:0] mem_addr_o;
    logic [31:0]   mem_rdata_i;
    logic          tx_o;
    logic          busy_o;
    logic          done_o;

    always #5 clk = ~clk;

    prog_readback_tx #(.AddrWidth(AW)) dut (
        .clk_i          (clk),
        .rst_i          (rst_i),
        .start_i        (start_i),
        .word_count_i   (word_count_i),
        .clks_per_bit_i (clks_per_bit_i),
        .mem_csb_o      (mem_csb_o),
        .mem_addr_o     (mem_addr_o),
        .mem_rdata_i    (mem_rdata_i),
        .tx_o           (tx_o),
        .busy_o         (busy_o),
        .done_o         (done_o)
    );

    // Synchronous-read SRAM; junk data when not selected exposes mistimed captures.
    logic [31:0] mem [256];
    always @(posedge clk) mem_rdata_i <= (!mem_csb_o) ? mem[mem_addr_o] : 32'hBAD0_BAD0;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;
    int sc = 0;          // cycle number following edge number sc-1
    int k = 0;           // edge at which start was sampled
    bit rec = 1'b0;
    bit done_seen = 1'b0;
    int done_cyc = 0;
    int txlow = 0;
    int tx_q[$];
    int exp_q[$];
    int rd_addr_q[$];
    int rd_cyc_q[$];

    task automatic chk(input string tag, input longint obs, input longint exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
        sc = cyc + 1;
        if (mem_csb_o === 1'b0) begin
            rd_addr_q.push_back(int'(mem_addr_o));
            rd_cyc_q.push_back(sc);
        end
        if (tx_o === 1'b0) txlow++;
        if (rec) tx_q.push_back((tx_o === 1'b1) ? 1 : 0);
        if (done_o === 1'b1) begin
            if (!done_seen) done_cyc = sc;
            done_seen = 1'b1;
            rec = 1'b0;
        end
    endtask

    task automatic start_run(input int wc, input int cpb);
        tx_q.delete();
        rd_addr_q.delete();
        rd_cyc_q.delete();
        done_seen = 1'b0;
        rec = 1'b1;
        word_count_i = 9'(wc);
        clks_per_bit_i = 16'(cpb);
        start_i = 1'b1;
        k = sc;
        step();
        start_i = 1'b0;
    endtask

    task automatic run_until_done(input string tag, input int maxc);
        for (int i = 0; i < maxc && !done_seen; i++) step();
        chk(tag, longint'(done_seen), 1);
    endtask

    // Ideal line: two idle cycles per word, then four 8N1 frames, then the done cycle.
    task automatic build_exp(input int words, input int cpb);
        exp_q.delete();
        for (int w = 0; w < words; w++) begin
            exp_q.push_back(1);
            exp_q.push_back(1);
            for (int b = 0; b < 4; b++) begin
                logic [31:0] word;
                word = mem[w];
                for (int c = 0; c < cpb; c++) exp_q.push_back(0);
                for (int j = 0; j < 8; j++)
                    for (int c = 0; c < cpb; c++) exp_q.push_back(int'(word[8*b+j]));
                for (int c = 0; c < cpb; c++) exp_q.push_back(1);
            end
        end
        exp_q.push_back(1);
    endtask

    task automatic check_stream(input string tag);
        int mism = 0;
        chk({tag, "_len"}, longint'(tx_q.size()), longint'(exp_q.size()));
        for (int i = 0; i < tx_q.size() && i < exp_q.size(); i++)
            if (tx_q[i] != exp_q[i]) mism++;
        chk({tag, "_wave"}, longint'(mism), 0);
    endtask

    task automatic check_reads(input string tag, input int words, input int cpb);
        int bad_addr = 0;
        int bad_gap = 0;
        chk({tag, "_nreads"}, longint'(rd_addr_q.size()), longint'(words));
        if (rd_addr_q.size() > 0) begin
            chk({tag, "_rd0_cyc"}, longint'(rd_cyc_q[0] - k), 1);
            for (int i = 0; i < rd_addr_q.size(); i++) begin
                if (rd_addr_q[i] != i) bad_addr++;
                if (i > 0 && (rd_cyc_q[i] - rd_cyc_q[i-1]) != 2 + 40*cpb) bad_gap++;
            end
            chk({tag, "_addr_order"}, longint'(bad_addr), 0);
            chk({tag, "_word_spacing"}, longint'(bad_gap), 0);
        end
    endtask

    initial begin
        int first0;
        int base;
        logic [7:0] dec;
        logic [7:0] exp_bytes [4];
        int txlow_base;

        rst_i = 1'b1;
        start_i = 1'b0;
        word_count_i = '0;
        clks_per_bit_i = 16'd4;

        // Reset values on the first sampled edge.
        step();
        chk("rst_tx", longint'(tx_o), 1);
        chk("rst_csb", longint'(mem_csb_o), 1);
        chk("rst_addr", longint'(mem_addr_o), 0);
        chk("rst_busy", longint'(busy_o), 0);
        chk("rst_done", longint'(done_o), 0);
        step();
        rst_i = 1'b0;
        step();

        // One word, cpb=4.
        mem[0] = 32'h1234_5678;
        mem[1] = 32'hCAFE_F00D;
        start_run(1, 4);
        chk("t1_busy", longint'(busy_o), 1);
        run_until_done("t1_done_seen", 400);
        chk("t1_done_cyc", longint'(done_cyc - k), 163);
        chk("t1_busy_at_done", longint'(busy_o), 0);
        first0 = -1;
        for (int i = tx_q.size() - 1; i >= 0; i--) if (tx_q[i] == 0) first0 = i;
        chk("t1_first_start_cyc", longint'(first0 + 1), 3);
        exp_bytes[0] = 8'h78; exp_bytes[1] = 8'h56; exp_bytes[2] = 8'h34; exp_bytes[3] = 8'h12;
        for (int b = 0; b < 4; b++) begin
            base = 2 + b*40;
            dec = '0;
            for (int j = 0; j < 8; j++)
                if (base + 4*(j+1) + 2 < tx_q.size()) dec[j] = tx_q[base + 4*(j+1) + 2][0];
            chk($sformatf("t1_byte%0d", b), longint'(dec), longint'(exp_bytes[b]));
        end
        build_exp(1, 4);
        check_stream("t1");
        check_reads("t1", 1, 4);
        step();

        // Zero words: immediate done, no SRAM access, line idle.
        start_run(0, 4);
        run_until_done("t0_done_seen", 20);
        chk("t0_done_cyc", longint'(done_cyc - k), 1);
        chk("t0_busy", longint'(busy_o), 0);
        build_exp(0, 4);
        check_stream("t0");
        check_reads("t0", 0, 4);
        step();

        // cpb=0 behaves as cpb=1.
        start_run(1, 0);
        run_until_done("tc0_done_seen", 200);
        chk("tc0_done_cyc", longint'(done_cyc - k), 43);
        build_exp(1, 1);
        check_stream("tc0");
        step();

        // Reset during data bit 3 of the second byte.
        start_run(2, 4);
        repeat (59) step();
        chk("tr_bit3_value", longint'(tx_o), 0);
        chk("tr_busy_before", longint'(busy_o), 1);
        rst_i = 1'b1;
        step();
        chk("tr_tx", longint'(tx_o), 1);
        chk("tr_busy", longint'(busy_o), 0);
        chk("tr_csb", longint'(mem_csb_o), 1);
        chk("tr_done", longint'(done_o), 0);
        rst_i = 1'b0;
        rec = 1'b0;
        rd_addr_q.delete();
        txlow_base = txlow;
        repeat (120) step();
        chk("tr_no_reads", longint'(rd_addr_q.size()), 0);
        chk("tr_no_tx", longint'(txlow - txlow_base), 0);
        chk("tr_no_done", longint'(done_seen), 0);

        // Start re-pulsed while busy and cpb input changed mid-dump: both ignored.
        start_run(2, 2);
        for (int i = 0; i < 400 && !done_seen; i++) begin
            step();
            start_i = ((sc - k) == 10) || ((sc - k) == 83) || ((sc - k) == 84);
            if (start_i) word_count_i = 9'd5;
            if ((sc - k) == 50) clks_per_bit_i = 16'd9;
        end
        chk("ts_done_seen", longint'(done_seen), 1);
        chk("ts_done_cyc", longint'(done_cyc - k), 165);
        build_exp(2, 2);
        check_stream("ts");
        check_reads("ts", 2, 2);
        // A start sampled while in DONE is also ignored.
        start_i = 1'b1;
        step();
        start_i = 1'b0;
        repeat (6) step();
        chk("ts_no_restart_reads", longint'(rd_addr_q.size()), 2);
        chk("ts_no_restart_busy", longint'(busy_o), 0);

        // Full memory, cpb=1: 256 words, no wrap, 2-cycle gaps.
        for (int i = 0; i < 256; i++)
            mem[i] = {8'(i), 8'(~i), 8'(i ^ 8'hA5), 8'(i * 3)};
        start_run(256, 1);
        run_until_done("tf_done_seen", 11000);
        chk("tf_done_cyc", longint'(done_cyc - k), 10753);
        build_exp(256, 1);
        check_stream("tf");
        check_reads("tf", 256, 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/prog_readback_tx.md
PROG_READBACK_TX -- requirements
Module: prog_readback_tx

Interface
REQ-001 SHALL have parameter AddrWidth, default 8: ICCM word-address width, matching the 256-word instruction SRAM.
REQ-002 SHALL have port clk_i, input, 1: single system clock; all logic is rising-edge.
REQ-003 SHALL have port rst_i, input, 1: reset, synchronous and active-high.
REQ-004 SHALL have port start_i, input, 1: one-cycle request to begin a readback.
REQ-005 SHALL have port word_count_i, input, AddrWidth+1: number of words to dump, starting at address 0 (0..256).
REQ-006 SHALL have port clks_per_bit_i, input, 16: UART bit period in clk_i cycles.
REQ-007 SHALL have port mem_csb_o, output, 1: active-low SRAM chip select, read-only (no write port).
REQ-008 SHALL have port mem_addr_o, output, AddrWidth: SRAM word address.
REQ-009 SHALL have port mem_rdata_i, input, 32: SRAM read data, valid the cycle after mem_csb_o is low.
REQ-010 SHALL have port tx_o, output, 1: UART serial out, idle high.
REQ-011 SHALL have port busy_o, output, 1: high from accepted start until dump completes.
REQ-012 SHALL have port done_o, output, 1: one-cycle pulse at completion.

Function
REQ-013 SHALL implement FSM states IDLE, RD_REQ, RD_WAIT, SEND, DONE.
REQ-014 SHALL in IDLE, on start_i=1, latch word_count_i and clks_per_bit_i, clear the word address, assert busy_o, and go to RD_REQ; when not in IDLE, start_i SHALL be ignored.
REQ-015 SHALL treat a latched clks_per_bit of 0 as 1.
REQ-016 SHALL, when the latched word_count is 0, go IDLE->DONE with no SRAM access and no tx_o activity.
REQ-017 SHALL in RD_REQ drive mem_csb_o=0 for exactly one cycle with mem_addr_o equal to the current word address, then go to RD_WAIT.
REQ-018 SHALL in RD_WAIT capture mem_rdata_i into a 32-bit shift buffer, then go to SEND.
REQ-019 SHALL in SEND transmit the four bytes in order: bits [7:0], [15:8], [23:16], [31:24].
REQ-020 SHALL frame each byte 8N1: start bit (0), 8 data bits LSB first, stop bit (1), each held exactly clks_per_bit cycles.
REQ-021 SHALL start each byte within a word immediately after the previous stop bit, with no idle gap.
REQ-022 SHALL, after the fourth stop bit, increment the word address and go to RD_REQ if address < word_count, else to DONE.
REQ-023 SHALL keep tx_o=1 in every state other than SEND, giving an inter-word idle gap of exactly 2 cycles (RD_REQ + RD_WAIT).
REQ-024 SHALL in DONE pulse done_o for one cycle, deassert busy_o in that same cycle, and return to IDLE.
REQ-025 SHALL, for start sampled at edge k, drive mem_csb_o=0 during cycle k+1 and tx_o=0 from cycle k+3.
REQ-026 SHALL use an internal address counter of AddrWidth+1 bits, so word_count=256 reads addresses 0..255 with no wrap and no reread.
REQ-027 SHALL keep mem_csb_o=1 in all states except RD_REQ.

Reset
REQ-028 SHALL, on rst_i=1 at any clock edge, including mid-frame, enter IDLE with tx_o=1, mem_csb_o=1, mem_addr_o=0, busy_o=0, done_o=0, and all counters cleared.
REQ-029 SHALL reach the reset values on the first edge rst_i is sampled high, with no partial byte emitted afterwards.

Structure
REQ-030 SHALL place the FSM state enum typedef and the constants BYTES_PER_WORD=4 and DATA_BITS=8 in shared package prog_readback_pkg.
REQ-031 SHALL instantiate sub-module uart_tx_byte: byte serializer with valid/ready handshake, runtime clks_per_bit, ready high only when the line is idle or a stop bit is completing.
REQ-032 SHALL take a byte into uart_tx_byte only on valid&&ready.

Verification
REQ-033 SHALL cover: word_count=1, cpb=4, mem[0]=0x12345678 -> bytes 0x78,0x56,0x34,0x12; 160 tx cycles; done_o at cycle k+163.
REQ-034 SHALL cover: word_count=0 -> done_o at k+1; mem_csb_o never low; tx_o constant 1.
REQ-035 SHALL cover: word_count=256, cpb=1 -> 256 reads at addresses 0..255 in order; 1024 bytes; exactly 2 idle cycles between words.
REQ-036 SHALL cover: start_i re-pulsed while busy_o=1 -> ignored; byte stream unchanged.
REQ-037 SHALL cover: rst_i asserted during data bit 3 of byte 1 -> tx_o=1 and busy_o=0 the next cycle; no further SRAM reads.
REQ-038 SHALL cover: cpb=0 latched -> same waveform as cpb=1; clks_per_bit_i changed mid-dump -> bit period unchanged.
